decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 58 +++++
 rtl/imm_gen.sv | 33 +++
 rtl/decode_stage.sv | 218 +++++++++++++++++++++
 tb/tb_decode_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU encodings, immediate formats,
// and the control-bundle struct carried in the decode output register.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [3:0] alu_ctrl;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    // ALU op for R-type and I-ALU; only R-type may select SUB.
    function automatic logic [3:0] alu_from_funct(input logic [2:0] f3,
                                                  input logic f7b5,
                                                  input logic is_r);
        case (f3)
            3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate and sign-extends
// it from instr[31] to XLEN. Opcode bits are not needed here.
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:7]     instr_i,
    input  imm_fmt_e        fmt_i,
    output logic [XLEN-1:0] imm_o
);

    logic signed [31:0] imm32;

    // Per-format bit shuffle into a 32-bit signed value
    always_comb begin
        imm32 = '0;
        case (fmt_i)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed cast widens with sign extension for XLEN=64
    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register file with write-through bypass, instruction
// decode, load-use interlock and a single valid/ready output register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_ready,
    output logic            if_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [3:0]      ex_alu_ctrl,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_illegal
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic            f7b5;
    ctrl_t           ctrl_d;
    imm_fmt_e        fmt;
    logic            use_rs1, use_rs2;
    logic [XLEN-1:0] imm_d, rs1_val_d, rs2_val_d;
    logic            hazard, transfer;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_pc_q, ex_rs1_val_q, ex_rs2_val_q, ex_imm_q;
    logic [4:0]      ex_rd_q, ex_rs1_q, ex_rs2_q;
    ctrl_t           ex_ctrl_q;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign f7b5   = if_instr[30];

    // Opcode decode into control bundle, immediate format and operand usage
    always_comb begin
        ctrl_d  = '0;
        fmt     = IMM_NONE;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b1);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IALU: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_from_funct(funct3, f7b5, 1'b0);
                fmt     = IMM_I;
                use_rs1 = 1'b1;
            end
            OP_LOAD: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.alu_ctrl   = ALU_ADD;
                fmt     = IMM_I;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                fmt     = IMM_S;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = ALU_SUB;
                fmt     = IMM_B;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                fmt = IMM_U;
            end
            OP_JAL: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                fmt = IMM_J;
            end
            OP_JALR: begin
                ctrl_d.jump      = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = ALU_ADD;
                fmt     = IMM_I;
                use_rs1 = 1'b1;
            end
            default: ctrl_d.illegal = 1'b1;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (if_instr[31:7]),
        .fmt_i   (fmt),
        .imm_o   (imm_d)
    );

    // x0 and out-of-range indices read 0; a same-cycle writeback wins over the array
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        if (a == 5'd0 || int'(a) >= NUM_REGS) return '0;
        if (wb_en && wb_addr == a)            return wb_data;
        return regs_q[a[IDX_W-1:0]];
    endfunction

    // Operand read with writeback bypass
    always_comb begin
        rs1_val_d = rf_read(rs1);
        rs2_val_d = rf_read(rs2);
    end

    assign hazard   = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != 5'd0) &&
                      ((use_rs1 && rs1 == ex_rd_q) || (use_rs2 && rs2 == ex_rd_q));
    assign if_ready = (!ex_valid_q || ex_ready) && !hazard && !flush;
    assign transfer = if_valid && if_ready;

    // Register file write; x0 and indices beyond NUM_REGS are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en && wb_addr != 5'd0 && int'(wb_addr) < NUM_REGS) begin
            regs_q[wb_addr[IDX_W-1:0]] <= wb_data;
        end
    end

    // Output register: flush/bubble clear everything, stall holds, transfer loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_ctrl_q    <= '0;
        end else if (transfer) begin
            ex_valid_q   <= 1'b1;
            ex_pc_q      <= if_pc;
            ex_rs1_val_q <= rs1_val_d;
            ex_rs2_val_q <= rs2_val_d;
            ex_imm_q     <= imm_d;
            ex_rd_q      <= rd;
            ex_rs1_q     <= rs1;
            ex_rs2_q     <= rs2;
            ex_ctrl_q    <= ctrl_d;
        end else if (flush || ex_ready || !ex_valid_q) begin
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_val_q <= '0;
            ex_rs2_val_q <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_ctrl_q    <= '0;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1_val    = ex_rs1_val_q;
    assign ex_rs2_val    = ex_rs2_val_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rd         = ex_rd_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_alu_ctrl   = ex_ctrl_q.alu_ctrl;
    assign ex_alu_src    = ex_ctrl_q.alu_src;
    assign ex_reg_write  = ex_ctrl_q.reg_write;
    assign ex_mem_read   = ex_ctrl_q.mem_read;
    assign ex_mem_write  = ex_ctrl_q.mem_write;
    assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
    assign ex_branch     = ex_ctrl_q.branch;
    assign ex_jump       = ex_ctrl_q.jump;
    assign ex_illegal    = ex_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage at XLEN=32: regfile, bypass, load-use
// interlock, stall hold, immediates, illegal opcode, flush and reset.
module tb_decode_stage;

    localparam int XLEN = 32;

    localparam logic [31:0] ADDI_X6_X5_1 = 32'h00128313;
    localparam logic [31:0] ADDI_X6_X0_1 = 32'h00100313;
    localparam logic [31:0] ADD_X8_X7_X0 = 32'h00038433;
    localparam logic [31:0] LD_X9_0_X1   = 32'h0000B483;
    localparam logic [31:0] ADD_X10_X9_2 = 32'h00248533;
    localparam logic [31:0] SUB_X3_X1_X2 = 32'h402081B3;
    localparam logic [31:0] SRA_X3_X1_X2 = 32'h4020D1B3;
    localparam logic [31:0] BEQ_M8       = 32'hFE000CE3;
    localparam logic [31:0] JAL_X1_800   = 32'h001000EF;
    localparam logic [31:0] SW_X2_M4_X1  = 32'hFE20AE23;
    localparam logic [31:0] LUI_X4       = 32'h12345237;
    localparam logic [31:0] ILLEGAL_7F   = 32'h0000007F;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            if_valid, flush, wb_en, ex_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc, wb_data;
    logic [4:0]      wb_addr;
    logic            if_ready, ex_valid;
    logic [XLEN-1:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]      ex_rd, ex_rs1, ex_rs2;
    logic [3:0]      ex_alu_ctrl;
    logic            ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write;
    logic            ex_mem_to_reg, ex_branch, ex_jump, ex_illegal;

    int total  = 0;
    int passed = 0;

    decode_stage #(.XLEN(XLEN), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_ready(ex_ready), .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val),
        .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_jump(ex_jump), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_alu_ctrl", ex_alu_ctrl, 0);
        chk("rst_if_ready", if_ready, 1);
        tick(); tick();
        rst_n = 1'b1;

        // write x5 then addi x6,x5,1
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        tick();
        wb_en = 1'b0; if_valid = 1'b1; if_instr = ADDI_X6_X5_1; if_pc = 32'h100;
        #1 chk("addi_if_ready", if_ready, 1);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_rs1_val", ex_rs1_val, 32'h1234);
        chk("addi_imm", ex_imm, 1);
        chk("addi_alu", ex_alu_ctrl, 4'b0010);
        chk("addi_alu_src", ex_alu_src, 1);
        chk("addi_rd", ex_rd, 6);
        chk("addi_pc", ex_pc, 32'h100);

        // bubble when nothing is offered
        if_valid = 1'b0;
        tick();
        chk("bubble_valid", ex_valid, 0);
        chk("bubble_reg_write", ex_reg_write, 0);
        chk("bubble_alu_src", ex_alu_src, 0);

        // same-cycle writeback bypass
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hFF;
        if_valid = 1'b1; if_instr = ADD_X8_X7_X0; if_pc = 32'h104;
        tick();
        wb_en = 1'b0;
        chk("byp_rs1_val", ex_rs1_val, 32'hFF);
        chk("byp_rs2_val", ex_rs2_val, 0);
        chk("byp_alu", ex_alu_ctrl, 4'b0010);
        chk("byp_alu_src", ex_alu_src, 0);

        // load-use interlock: exactly one bubble
        if_instr = LD_X9_0_X1; if_pc = 32'h108;
        tick();
        chk("ld_mem_read", ex_mem_read, 1);
        chk("ld_mem_to_reg", ex_mem_to_reg, 1);
        chk("ld_rd", ex_rd, 9);
        if_instr = ADD_X10_X9_2; if_pc = 32'h10C;
        #1 chk("lu_if_ready", if_ready, 0);
        tick();
        chk("lu_bubble_valid", ex_valid, 0);
        chk("lu_if_ready_after", if_ready, 1);
        tick();
        chk("lu_add_valid", ex_valid, 1);
        chk("lu_add_rd", ex_rd, 10);
        chk("lu_add_rs1", ex_rs1, 9);
        chk("lu_add_rs2", ex_rs2, 2);

        // downstream stall for 3 cycles
        ex_ready = 1'b0; if_instr = SUB_X3_X1_X2; if_pc = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_if_ready", if_ready, 0);
            tick();
            chk("stall_valid", ex_valid, 1);
            chk("stall_rd", ex_rd, 10);
            chk("stall_pc", ex_pc, 32'h10C);
            chk("stall_alu", ex_alu_ctrl, 4'b0010);
        end
        ex_ready = 1'b1;
        #1 chk("unstall_if_ready", if_ready, 1);
        tick();
        chk("sub_alu", ex_alu_ctrl, 4'b0110);
        chk("sub_pc", ex_pc, 32'h200);
        if_instr = SRA_X3_X1_X2;
        tick();
        chk("sra_alu", ex_alu_ctrl, 4'b0111);

        // immediates and illegal opcode
        if_instr = BEQ_M8;
        tick();
        chk("beq_imm", ex_imm, 32'hFFFFFFF8);
        chk("beq_branch", ex_branch, 1);
        chk("beq_alu", ex_alu_ctrl, 4'b0110);
        if_instr = JAL_X1_800;
        tick();
        chk("jal_imm", ex_imm, 32'h00000800);
        chk("jal_jump", ex_jump, 1);
        chk("jal_reg_write", ex_reg_write, 1);
        if_instr = SW_X2_M4_X1;
        tick();
        chk("sw_imm", ex_imm, 32'hFFFFFFFC);
        chk("sw_mem_write", ex_mem_write, 1);
        chk("sw_reg_write", ex_reg_write, 0);
        if_instr = LUI_X4;
        tick();
        chk("lui_imm", ex_imm, 32'h12345000);
        if_instr = ILLEGAL_7F;
        tick();
        chk("ill_flag", ex_illegal, 1);
        chk("ill_valid", ex_valid, 1);
        chk("ill_reg_write", ex_reg_write, 0);
        chk("ill_alu", ex_alu_ctrl, 4'b0000);

        // flush together with if_valid
        if_instr = ADDI_X6_X5_1; flush = 1'b1;
        #1 chk("flush_if_ready", if_ready, 0);
        tick();
        chk("flush_valid", ex_valid, 0);
        flush = 1'b0;

        // write to x0 is ignored, including for bypass
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        if_instr = ADDI_X6_X0_1;
        tick();
        chk("x0_byp_rs1_val", ex_rs1_val, 0);
        wb_en = 1'b0;
        tick();
        chk("x0_rs1_val", ex_rs1_val, 0);
        chk("x0_imm", ex_imm, 1);

        // flush overrides a stalled hold
        ex_ready = 1'b0; flush = 1'b1;
        tick();
        chk("flush_stall_valid", ex_valid, 0);
        flush = 1'b0; ex_ready = 1'b1;

        // async reset in the middle of a stall
        if_instr = ADDI_X6_X5_1; if_pc = 32'h300;
        tick();
        ex_ready = 1'b0;
        tick();
        chk("pre_rst_valid", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", ex_valid, 0);
        chk("async_rst_pc", ex_pc, 0);
        chk("async_rst_if_ready", if_ready, 1);
        if_valid = 1'b0; ex_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_no_xfer", ex_valid, 0);
        if_valid = 1'b1;
        tick();
        chk("post_rst_x5_cleared", ex_rs1_val, 0);
        chk("post_rst_valid", ex_valid, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
